// File: rtl/mul_issue_ctrl.sv
`timescale 1ns/1ps
// Issue/retire controller for the sequential multiplier: buffers operand pairs,
// drives the valid_data/Done_Flag/ack handshake, and captures product + latency.
//
// state | meaning
// IDLE  | waiting for a buffered pair and a free result register
// ISSUE | operands presented, valid_data high, counting cycles to Done_Flag
// ACK   | product captured, ack held until Done_Flag falls
module mul_issue_ctrl #(
    parameter int W       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int LATW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_valid_data,
    output logic              mul_ack,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_producto,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_producto,
    output logic [LATW-1:0]   out_lat,
    output logic              timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [W-1:0]        r_mem_a [DEPTH];
    logic [W-1:0]        r_mem_b [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [W-1:0]        r_mul_a;
    logic [W-1:0]        r_mul_b;
    logic                r_mul_valid;
    logic                r_mul_ack;
    logic                r_out_valid;
    logic [2*W-1:0]      r_out_prod;
    logic [LATW-1:0]     r_out_lat;
    logic [LATW-1:0]     r_lat;
    logic                r_timeout_err;

    logic [W-1:0]        w_mul_a_nxt;
    logic [W-1:0]        w_mul_b_nxt;
    logic                w_mul_valid_nxt;
    logic                w_mul_ack_nxt;
    logic                w_out_valid_nxt;
    logic [2*W-1:0]      w_out_prod_nxt;
    logic [LATW-1:0]     w_out_lat_nxt;
    logic [LATW-1:0]     w_lat_nxt;
    logic                w_timeout_err_nxt;

    logic                w_in_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_lat_tc;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // push even when a pop happens in the same cycle.
    assign w_in_ready = (r_count != CW'(DEPTH));
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && !r_out_valid;
    assign w_lat_tc   = (r_lat == LATW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mul_done) begin
                    w_state_nxt = S_ACK;
                end else if (w_lat_tc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                if (!mul_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mul_a_nxt       = r_mul_a;
        w_mul_b_nxt       = r_mul_b;
        w_mul_valid_nxt   = r_mul_valid;
        w_mul_ack_nxt     = r_mul_ack;
        w_out_valid_nxt   = r_out_valid;
        w_out_prod_nxt    = r_out_prod;
        w_out_lat_nxt     = r_out_lat;
        w_lat_nxt         = r_lat;
        w_timeout_err_nxt = r_timeout_err;

        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_mul_a_nxt     = r_mem_a[r_rd_ptr];
                    w_mul_b_nxt     = r_mem_b[r_rd_ptr];
                    w_mul_valid_nxt = 1'b1;
                    w_lat_nxt       = LATW'(1);
                end
            end
            S_ISSUE: begin
                // Done_Flag wins over the timeout on the terminal cycle.
                if (mul_done) begin
                    w_out_prod_nxt  = mul_producto;
                    w_out_lat_nxt   = r_lat;
                    w_out_valid_nxt = 1'b1;
                    w_mul_valid_nxt = 1'b0;
                    w_mul_ack_nxt   = 1'b1;
                end else if (w_lat_tc) begin
                    w_mul_valid_nxt   = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_lat_nxt = r_lat + LATW'(1);
                end
            end
            S_ACK: begin
                if (!mul_done) begin
                    w_mul_ack_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_mul_valid   <= 1'b0;
            r_mul_ack     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_prod    <= '0;
            r_out_lat     <= '0;
            r_lat         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mul_a       <= w_mul_a_nxt;
            r_mul_b       <= w_mul_b_nxt;
            r_mul_valid   <= w_mul_valid_nxt;
            r_mul_ack     <= w_mul_ack_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_prod    <= w_out_prod_nxt;
            r_out_lat     <= w_out_lat_nxt;
            r_lat         <= w_lat_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign in_ready       = w_in_ready;
    assign mul_a          = r_mul_a;
    assign mul_b          = r_mul_b;
    assign mul_valid_data = r_mul_valid;
    assign mul_ack        = r_mul_ack;
    assign out_valid      = r_out_valid;
    assign out_producto   = r_out_prod;
    assign out_lat        = r_out_lat;
    assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for mul_issue_ctrl with a behavioural multiplier stub
// whose Done_Flag latency, ack hold time and "never done" mode are adjustable.
module tb_mul_issue_ctrl;

    localparam int W          = 32;
    localparam int DEPTH      = 4;
    localparam int TB_TIMEOUT = 40;
    localparam int LATW       = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_valid_data;
    logic              mul_ack;
    logic              mul_done;
    logic [2*W-1:0]    mul_producto;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    out_producto;
    logic [LATW-1:0]   out_lat;
    logic              timeout_err;

    always #5 clk = ~clk;

    mul_issue_ctrl #(
        .W(W), .DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT), .LATW(LATW)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid_data(mul_valid_data),
        .mul_ack(mul_ack), .mul_done(mul_done), .mul_producto(mul_producto),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_producto(out_producto), .out_lat(out_lat), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [2*W-1:0]  prod;
        logic [LATW-1:0] lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Multiplier stub: Done_Flag on the lat_n-th valid cycle, held for hold_n ack edges.
    int   lat_n      = 3;
    int   hold_n     = 1;
    bit   stub_never = 1'b0;
    bit   force_done = 1'b0;
    int   s_cnt;
    bit   s_done;
    int   s_hcnt;

    always @(posedge clk) begin
        if (!reset) begin
            s_cnt  <= 0;
            s_done <= 1'b0;
            s_hcnt <= 0;
        end else if (!s_done) begin
            if (mul_valid_data) begin
                if (!stub_never && s_cnt == lat_n - 1) begin
                    s_done <= 1'b1;
                    s_cnt  <= 0;
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end else begin
                s_cnt <= 0;
            end
        end else if (mul_ack) begin
            if (s_hcnt == hold_n - 1) begin
                s_done <= 1'b0;
                s_hcnt <= 0;
            end else begin
                s_hcnt <= s_hcnt + 1;
            end
        end
    end

    assign mul_done = s_done | force_done |
                      (mul_valid_data && !stub_never && !s_done && (s_cnt == lat_n - 1));
    assign mul_producto = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result monitor and valid_data pulse tracking.
    int n_issue    = 0;
    int run        = 0;
    int last_pulse = 0;
    bit vld_d      = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (mul_valid_data && !vld_d) n_issue++;
            if (mul_valid_data) run++;
            else if (vld_d) begin
                last_pulse = run;
                run = 0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", out_producto, 64'hx);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_product", out_producto, mon_e.prod);
                    chk("sb_lat", {56'd0, out_lat}, {56'd0, mon_e.lat});
                end
            end
        end else begin
            run = 0;
        end
        vld_d = mul_valid_data;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
        logic [63:0] p;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
        chk("push_accept", in_ready, 1);
        p = {32'd0, a} * {32'd0, b};
        if (in_ready && track) sb.push_back('{prod: p, lat: LATW'(lat_n)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_try(input logic [W-1:0] a, input logic [W-1:0] b, output bit acc);
        logic [63:0] p;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        acc = in_ready;
        p = {32'd0, a} * {32'd0, b};
        if (acc) sb.push_back('{prod: p, lat: LATW'(lat_n)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int max);
        for (int i = 0; i < max && !out_valid; i++) @(negedge clk);
        chk(tag, out_valid, 1);
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) @(negedge clk);
        chk(tag, sb.size(), 0);
        tick(3);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
        chk({tag, "_valid_data"}, mul_valid_data, 0);
        chk({tag, "_ack"}, mul_ack, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_producto"}, out_producto, 0);
        chk({tag, "_out_lat"}, out_lat, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        int  nacc;
        bit  acc;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        tick(3);
        check_zero("reset");
        reset = 1'b1;

        // Basic product and ack handshake
        n0 = n_issue;
        push(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_out("basic_wait", 100);
        chk("basic_prod", out_producto, 64'hFFFFFFFE00000001);
        chk("basic_ack_set", mul_ack, 1);
        chk("basic_valid_low", mul_valid_data, 0);
        tick(1);
        chk("basic_out_valid_1cyc", out_valid, 0);
        chk("basic_ack_hold", mul_ack, 1);
        tick(1);
        chk("basic_ack_clear", mul_ack, 0);
        drain("basic_drain", 50);
        chk("basic_issues", n_issue - n0, 1);

        // Back-to-back ordering
        n0 = n_issue;
        push(32'd3, 32'd5, 1'b1);
        push(32'd7, 32'd9, 1'b1);
        push(32'd0, 32'h12345678, 1'b1);
        drain("b2b_drain", 300);
        chk("b2b_issues", n_issue - n0, 3);

        // Latency capture, including Done_Flag on the terminal ISSUE cycle
        lat_n = 33;
        push(32'd6, 32'd7, 1'b1);
        wait_out("lat33_wait", 200);
        chk("lat33_out_lat", out_lat, 33);
        drain("lat33_drain", 50);
        lat_n = TB_TIMEOUT;
        push(32'd9, 32'd9, 1'b1);
        wait_out("latmax_wait", 200);
        chk("latmax_out_lat", out_lat, TB_TIMEOUT);
        chk("latmax_no_timeout", timeout_err, 0);
        drain("latmax_drain", 50);
        lat_n = 3;

        // Done_Flag while IDLE is ignored
        force_done = 1'b1;
        tick(4);
        chk("idle_done_out_valid", out_valid, 0);
        chk("idle_done_ack", mul_ack, 0);
        force_done = 1'b0;
        tick(2);

        // Full FIFO and backpressure
        out_ready = 1'b0;
        n0 = n_issue;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            push_try(W'(i + 1), W'(i + 2), acc);
            nacc += int'(acc);
        end
        chk("bp_accepted", nacc, 5);
        in_valid = 1'b1;
        wait_out("bp_wait", 100);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_prod", out_producto, 64'd2);
            chk("bp_hold_lat", out_lat, 3);
            chk("bp_no_issue", mul_valid_data, 0);
            chk("bp_full", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("bp_drain", 400);
        chk("bp_issues", n_issue - n0, 5);

        // Timeout: first pair never completes, next pair still issues
        stub_never = 1'b1;
        push(32'd5, 32'd5, 1'b0);
        push(32'd11, 32'd13, 1'b1);
        for (int i = 0; i < 200 && !timeout_err; i++) begin
            @(negedge clk);
            chk("to_no_out_valid", out_valid, 0);
        end
        stub_never = 1'b0;
        chk("to_err_set", timeout_err, 1);
        tick(1);
        chk("to_pulse_len", last_pulse, TB_TIMEOUT);
        drain("to_drain", 100);
        chk("to_sticky", timeout_err, 1);

        // Reset during ISSUE flushes FIFO and in-flight operation
        out_ready = 1'b0;
        lat_n = 20;
        push(32'd2, 32'd3, 1'b0);
        push(32'd4, 32'd5, 1'b0);
        for (int i = 0; i < 50 && !mul_valid_data; i++) @(negedge clk);
        tick(3);
        chk("rst_issue_active", mul_valid_data, 1);
        reset = 1'b0;
        tick(1);
        check_zero("rst_issue");
        reset = 1'b1;
        tick(10);
        chk("rst_issue_fifo_empty", mul_valid_data, 0);
        chk("rst_issue_no_out", out_valid, 0);

        // Reset during ACK
        lat_n = 3;
        hold_n = 6;
        push(32'd2, 32'd3, 1'b0);
        push(32'd7, 32'd7, 1'b0);
        for (int i = 0; i < 50 && !mul_ack; i++) @(negedge clk);
        tick(1);
        chk("rst_ack_active", mul_ack, 1);
        reset = 1'b0;
        tick(1);
        check_zero("rst_ack");
        reset = 1'b1;
        hold_n = 1;
        tick(10);
        chk("rst_ack_fifo_empty", mul_valid_data, 0);

        // Post-reset operation
        out_ready = 1'b1;
        push(32'd2, 32'd2, 1'b1);
        wait_out("post_rst_wait", 100);
        chk("post_rst_prod", out_producto, 64'd4);
        drain("post_rst_drain", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
